// File: rtl/drive_pkg.sv
// drive_pkg
//   Shared types and constants for the line-follower drive controller:
//   planner action codes, motor direction codes, the per-period motor
//   command record, the line decoder's steer classes and the controller's
//   two-state phase.
//   No ports (package).
package drive_pkg;

  typedef enum logic [2:0] {
    ACT_FOLLOW  = 3'b000,
    ACT_LEFT    = 3'b001,
    ACT_RIGHT   = 3'b010,
    ACT_STOP    = 3'b011,
    ACT_REVERSE = 3'b100
  } action_t;

  typedef enum logic [1:0] {
    DIR_STOP = 2'b00,
    DIR_CW   = 2'b01,
    DIR_CCW  = 2'b10
  } dir_t;

  typedef struct packed {
    logic l_en;
    dir_t l_dir;
    logic r_en;
    dir_t r_dir;
  } motor_cmd_t;

  typedef enum logic [2:0] {
    STEER_FWD,
    STEER_GLEFT,
    STEER_SLEFT,
    STEER_GRIGHT,
    STEER_SRIGHT,
    STEER_CROSS
  } steer_t;

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // A disabled motor's direction field is never seen at the pins that
  // matter (its reset holds it idle), so it is parked at DIR_STOP.
  localparam motor_cmd_t CMD_FWD    = '{l_en: 1'b1, l_dir: DIR_CCW,  r_en: 1'b1, r_dir: DIR_CW};
  localparam motor_cmd_t CMD_BACK   = '{l_en: 1'b1, l_dir: DIR_CW,   r_en: 1'b1, r_dir: DIR_CCW};
  localparam motor_cmd_t CMD_GLEFT  = '{l_en: 1'b0, l_dir: DIR_STOP, r_en: 1'b1, r_dir: DIR_CW};
  localparam motor_cmd_t CMD_SLEFT  = '{l_en: 1'b1, l_dir: DIR_CW,   r_en: 1'b1, r_dir: DIR_CW};
  localparam motor_cmd_t CMD_GRIGHT = '{l_en: 1'b1, l_dir: DIR_CCW,  r_en: 1'b0, r_dir: DIR_STOP};
  localparam motor_cmd_t CMD_SRIGHT = '{l_en: 1'b1, l_dir: DIR_CCW,  r_en: 1'b1, r_dir: DIR_CCW};
  localparam motor_cmd_t CMD_BRAKE  = '{l_en: 1'b1, l_dir: DIR_STOP, r_en: 1'b1, r_dir: DIR_STOP};

  // Unknown action codes degrade to a stop.
  function automatic action_t decode_action(input logic [2:0] code);
    case (code)
      3'b000:  return ACT_FOLLOW;
      3'b001:  return ACT_LEFT;
      3'b010:  return ACT_RIGHT;
      3'b100:  return ACT_REVERSE;
      default: return ACT_STOP;
    endcase
  endfunction

  function automatic motor_cmd_t steer_to_cmd(input steer_t s);
    case (s)
      STEER_GLEFT:  return CMD_GLEFT;
      STEER_SLEFT:  return CMD_SLEFT;
      STEER_GRIGHT: return CMD_GRIGHT;
      STEER_SRIGHT: return CMD_SRIGHT;
      STEER_CROSS:  return CMD_BRAKE;
      default:      return CMD_FWD;
    endcase
  endfunction

endpackage

// File: rtl/line_decoder.sv
// line_decoder
//   Combinational floor-sensor classifier. Counts line (0) readings on each
//   side of the middle sensor and picks a steer class.
//   Ports:
//     sensor [SENSOR_W] in  : 1 = white, 0 = line; MSB is leftmost
//     steer  (steer_t)  out : FWD / GLEFT / SLEFT / GRIGHT / SRIGHT / CROSS
module line_decoder
  import drive_pkg::*;
#(
  parameter int SENSOR_W = 3
) (
  input  logic [SENSOR_W-1:0] sensor,
  output steer_t              steer
);

  localparam int M     = SENSOR_W / 2;
  localparam int CNT_W = $clog2(SENSOR_W + 1);

  logic [CNT_W-1:0] l_cnt;
  logic [CNT_W-1:0] r_cnt;

  always_comb begin
    l_cnt = '0;
    r_cnt = '0;
    for (int i = 0; i < M; i++) begin
      r_cnt = r_cnt + CNT_W'(~sensor[i]);
      l_cnt = l_cnt + CNT_W'(~sensor[M + 1 + i]);
    end
  end

  // Middle sensor on the line means a gentle correction (one wheel idle);
  // middle on white means the line is drifting away, so spin in place.
  always_comb begin
    steer = STEER_FWD;
    if (sensor == '0) begin
      steer = STEER_CROSS;
    end else if (l_cnt > r_cnt) begin
      steer = sensor[M] ? STEER_SLEFT : STEER_GLEFT;
    end else if (r_cnt > l_cnt) begin
      steer = sensor[M] ? STEER_SRIGHT : STEER_GRIGHT;
    end
  end

endmodule

// File: rtl/drive_sequencer.sv
// drive_sequencer
//   Per-period drive controller. A one-cycle SYNC restarts the shared
//   timebase and latches the next period's motor command; RUN then drives
//   that command until the timebase reaches PERIOD.
//   Ports:
//     clk, reset                 : clock, synchronous active-high reset
//     sensor [SENSOR_W]      in  : floor sensor bar (1 = white)
//     count_in [COUNT_W]     in  : shared timebase count
//     count_reset            out : restarts the timebase (high in SYNC)
//     action [3], action_valid in / action_ready out : planner handshake
//     action_done            out : 1-cycle completion pulse (in SYNC)
//     action_timeout         out : qualifies action_done for timed-out turns
//     motor_{l,r}_reset      out : 1 = motor generates no pulses
//     motor_{l,r}_direction  out : 01 cw, 10 ccw, 00 stop
module drive_sequencer
  import drive_pkg::*;
#(
  parameter int SENSOR_W    = 3,
  parameter int COUNT_W     = 21,
  parameter int PERIOD      = 2_000_000,
  parameter int TURN_MAX    = 8,
  parameter int REV_PERIODS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SENSOR_W-1:0] sensor,
  input  logic [COUNT_W-1:0]  count_in,
  output logic                count_reset,
  input  logic [2:0]          action,
  input  logic                action_valid,
  output logic                action_ready,
  output logic                action_done,
  output logic                action_timeout,
  output logic                motor_l_reset,
  output logic                motor_r_reset,
  output logic [1:0]          motor_l_direction,
  output logic [1:0]          motor_r_direction
);

  localparam int M      = SENSOR_W / 2;
  localparam int PMAX   = (TURN_MAX > REV_PERIODS) ? TURN_MAX : REV_PERIODS;
  localparam int PCNT_W = $clog2(PMAX + 1);
  localparam logic [COUNT_W-1:0] PERIOD_C = COUNT_W'(PERIOD);

  state_t            state_reg, state_next;
  logic              pending_reg, pending_next;
  action_t           pend_act_reg, pend_act_next;
  logic              active_reg, active_next;
  action_t           act_reg, act_next;
  logic [PCNT_W-1:0] period_cnt_reg, period_cnt_next;
  logic [PCNT_W-1:0] period_inc;
  logic              seen_white_reg, seen_white_next;
  motor_cmd_t        cmd_reg, cmd_next;
  logic              done_c, timeout_c;
  steer_t            steer;
  motor_cmd_t        steer_cmd;

  line_decoder #(.SENSOR_W(SENSOR_W)) u_line_decoder (
    .sensor (sensor),
    .steer  (steer)
  );

  assign steer_cmd  = steer_to_cmd(steer);
  assign period_inc = period_cnt_reg + PCNT_W'(1);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_SYNC;
    else       state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_SYNC: state_next = ST_RUN;
      ST_RUN:  if (count_in >= PERIOD_C) state_next = ST_SYNC;
      default: state_next = ST_SYNC;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    action_ready = !pending_reg && !active_reg;
    if (state_reg == ST_SYNC) begin
      count_reset       = 1'b1;
      motor_l_reset     = 1'b1;
      motor_r_reset     = 1'b1;
      motor_l_direction = DIR_CW;
      motor_r_direction = DIR_CW;
      action_done       = done_c;
      action_timeout    = timeout_c;
    end else begin
      count_reset       = 1'b0;
      motor_l_reset     = !cmd_reg.l_en;
      motor_r_reset     = !cmd_reg.r_en;
      motor_l_direction = cmd_reg.l_dir;
      motor_r_direction = cmd_reg.r_dir;
      action_done       = 1'b0;
      action_timeout    = 1'b0;
    end
  end

  // ---------------- action sequencing ----------------
  // Everything is decided in SYNC. An action activated in a SYNC only sets
  // up its first period; completion is judged at the SYNCs that end its
  // periods. Follow is the exception: it needs the sensors to pick its
  // first command, so a crossing under the robot finishes it at once.
  always_comb begin
    pending_next    = pending_reg;
    pend_act_next   = pend_act_reg;
    active_next     = active_reg;
    act_next        = act_reg;
    period_cnt_next = period_cnt_reg;
    seen_white_next = seen_white_reg;
    cmd_next        = cmd_reg;
    done_c          = 1'b0;
    timeout_c       = 1'b0;

    if (state_reg == ST_SYNC) begin
      if (active_reg) begin
        case (act_reg)
          ACT_FOLLOW: begin
            if (steer == STEER_CROSS) done_c = 1'b1;
            else                      cmd_next = steer_cmd;
          end
          ACT_LEFT, ACT_RIGHT: begin
            period_cnt_next = period_inc;
            if (sensor[M]) seen_white_next = 1'b1;
            // Back on the line after leaving it wins over the timeout.
            if (seen_white_reg && !sensor[M]) begin
              done_c = 1'b1;
            end else if (period_inc >= PCNT_W'(TURN_MAX)) begin
              done_c    = 1'b1;
              timeout_c = 1'b1;
            end else begin
              cmd_next = (act_reg == ACT_LEFT) ? CMD_SLEFT : CMD_SRIGHT;
            end
          end
          ACT_REVERSE: begin
            period_cnt_next = period_inc;
            if (period_inc >= PCNT_W'(REV_PERIODS)) done_c = 1'b1;
            else                                    cmd_next = CMD_BACK;
          end
          default: done_c = 1'b1;
        endcase
        if (done_c) begin
          active_next = 1'b0;
          cmd_next    = CMD_BRAKE;
        end
      end else if (pending_reg) begin
        pending_next    = 1'b0;
        active_next     = 1'b1;
        act_next        = pend_act_reg;
        period_cnt_next = '0;
        seen_white_next = 1'b0;
        case (pend_act_reg)
          ACT_FOLLOW: begin
            if (steer == STEER_CROSS) begin
              done_c      = 1'b1;
              active_next = 1'b0;
              cmd_next    = CMD_BRAKE;
            end else begin
              cmd_next = steer_cmd;
            end
          end
          ACT_LEFT:    cmd_next = CMD_SLEFT;
          ACT_RIGHT:   cmd_next = CMD_SRIGHT;
          ACT_REVERSE: cmd_next = CMD_BACK;
          default:     cmd_next = CMD_BRAKE;
        endcase
      end else begin
        cmd_next = CMD_BRAKE;
      end
    end

    // action_ready excludes a pending or active action, so this never
    // collides with the activation path above.
    if (action_valid && action_ready) begin
      pending_next  = 1'b1;
      pend_act_next = decode_action(action);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg    <= 1'b0;
      pend_act_reg   <= ACT_STOP;
      active_reg     <= 1'b0;
      act_reg        <= ACT_STOP;
      period_cnt_reg <= '0;
      seen_white_reg <= 1'b0;
      cmd_reg        <= CMD_BRAKE;
    end else begin
      pending_reg    <= pending_next;
      pend_act_reg   <= pend_act_next;
      active_reg     <= active_next;
      act_reg        <= act_next;
      period_cnt_reg <= period_cnt_next;
      seen_white_reg <= seen_white_next;
      cmd_reg        <= cmd_next;
    end
  end

endmodule

// File: tb/tb_drive_sequencer.sv
// tb_drive_sequencer
//   Self-checking bench: a period-level reference model predicts every
//   cycle's outputs from the controller's rules; directed scenarios add
//   literal expectations, then randomized traffic runs against the model.
module tb_drive_sequencer;

  localparam int SW     = 5;
  localparam int CW     = 21;
  localparam int PER    = 10;
  localparam int TMAX   = 3;
  localparam int REV    = 2;
  localparam int PLEN   = PER + 2;

  // bench-side command / action names
  localparam int C_BRAKE = 0, C_FWD = 1, C_BACK = 2, C_GLEFT = 3,
                 C_SLEFT = 4, C_GRIGHT = 5, C_SRIGHT = 6, C_CROSS = 7;
  localparam int A_FOLLOW = 0, A_LEFT = 1, A_RIGHT = 2, A_STOP = 3, A_REVERSE = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [SW-1:0] sensor = 5'b11011;
  logic [CW-1:0] count_in = '0;
  logic          count_reset;
  logic [2:0]    action = 3'b000;
  logic          action_valid = 1'b0;
  logic          action_ready, action_done, action_timeout;
  logic          motor_l_reset, motor_r_reset;
  logic [1:0]    motor_l_direction, motor_r_direction;

  int errors = 0;
  int checks = 0;

  // reference model state (post-edge values)
  int m_phase = 0;
  bit m_pend = 0;
  int m_pend_act = 0;
  bit m_on = 0;
  int m_act = 0;
  int m_periods = 0;
  bit m_seen = 0;
  int m_cmd = C_BRAKE;

  drive_sequencer #(
    .SENSOR_W(SW), .COUNT_W(CW), .PERIOD(PER), .TURN_MAX(TMAX), .REV_PERIODS(REV)
  ) dut (
    .clk(clk), .reset(reset), .sensor(sensor), .count_in(count_in),
    .count_reset(count_reset), .action(action), .action_valid(action_valid),
    .action_ready(action_ready), .action_done(action_done),
    .action_timeout(action_timeout), .motor_l_reset(motor_l_reset),
    .motor_r_reset(motor_r_reset), .motor_l_direction(motor_l_direction),
    .motor_r_direction(motor_r_direction)
  );

  always #5 clk = ~clk;

  // free-running shared timebase
  always @(posedge clk) count_in <= count_reset ? '0 : count_in + 1'b1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [1:0] got, input logic [1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, got, want);
    end
  endtask

  function automatic int decode(input bit [SW-1:0] s);
    int l, r;
    if (s == '0) return C_CROSS;
    l = (s[4] ? 0 : 1) + (s[3] ? 0 : 1);
    r = (s[1] ? 0 : 1) + (s[0] ? 0 : 1);
    if (l > r) return s[2] ? C_SLEFT : C_GLEFT;
    if (r > l) return s[2] ? C_SRIGHT : C_GRIGHT;
    return C_FWD;
  endfunction

  // expected pins for a command; a disabled motor's direction is not checked
  task automatic cmd_pins(input int c, output bit lr, output bit [1:0] ld,
                          output bit rr, output bit [1:0] rd);
    lr = 0; rr = 0; ld = 2'b00; rd = 2'b00;
    case (c)
      C_FWD:    begin ld = 2'b10; rd = 2'b01; end
      C_BACK:   begin ld = 2'b01; rd = 2'b10; end
      C_GLEFT:  begin lr = 1;     rd = 2'b01; end
      C_SLEFT:  begin ld = 2'b01; rd = 2'b01; end
      C_GRIGHT: begin ld = 2'b10; rr = 1;     end
      C_SRIGHT: begin ld = 2'b10; rd = 2'b10; end
      default:  begin ld = 2'b00; rd = 2'b00; end
    endcase
  endtask

  // One clock cycle: predict, compare, advance the model, wait for negedge.
  task automatic step();
    bit ex_ready, ex_done, ex_to, acc, lr, rr;
    bit [1:0] ld, rd;
    bit n_pend, n_on, n_seen;
    int n_pend_act, n_act, n_periods, n_cmd, d, n;
    #1;
    ex_ready = !(m_pend || m_on);
    ex_done = 0; ex_to = 0;
    n_pend = m_pend; n_pend_act = m_pend_act; n_on = m_on; n_act = m_act;
    n_periods = m_periods; n_seen = m_seen; n_cmd = m_cmd;
    if (m_phase == 0) begin
      d = decode(sensor);
      if (m_on) begin
        n = m_periods + 1;
        n_periods = n;
        case (m_act)
          A_FOLLOW: if (d == C_CROSS) ex_done = 1; else n_cmd = d;
          A_LEFT, A_RIGHT: begin
            if (m_seen && !sensor[2]) ex_done = 1;
            else if (n >= TMAX) begin ex_done = 1; ex_to = 1; end
            else n_cmd = (m_act == A_LEFT) ? C_SLEFT : C_SRIGHT;
            if (sensor[2]) n_seen = 1;
          end
          A_REVERSE: if (n >= REV) ex_done = 1; else n_cmd = C_BACK;
          default: ex_done = 1;
        endcase
        if (ex_done) begin n_on = 0; n_cmd = C_BRAKE; end
      end else if (m_pend) begin
        n_pend = 0; n_on = 1; n_act = m_pend_act; n_periods = 0; n_seen = 0;
        case (m_pend_act)
          A_FOLLOW: if (d == C_CROSS) begin ex_done = 1; n_on = 0; n_cmd = C_BRAKE; end
                    else n_cmd = d;
          A_LEFT:    n_cmd = C_SLEFT;
          A_RIGHT:   n_cmd = C_SRIGHT;
          A_REVERSE: n_cmd = C_BACK;
          default:   n_cmd = C_BRAKE;
        endcase
      end else begin
        n_cmd = C_BRAKE;
      end
    end
    acc = action_valid && ex_ready;
    if (acc) begin
      n_pend = 1;
      n_pend_act = (action > 3'd4) ? A_STOP : int'(action);
    end

    chk("ready", {1'b0, action_ready}, {1'b0, ex_ready});
    if (m_phase == 0) begin
      chk("count_reset", {1'b0, count_reset}, 2'b01);
      chk("l_reset", {1'b0, motor_l_reset}, 2'b01);
      chk("r_reset", {1'b0, motor_r_reset}, 2'b01);
      chk("l_dir", motor_l_direction, 2'b01);
      chk("r_dir", motor_r_direction, 2'b01);
      chk("done", {1'b0, action_done}, {1'b0, ex_done});
      chk("timeout", {1'b0, action_timeout}, {1'b0, ex_to});
    end else begin
      cmd_pins(m_cmd, lr, ld, rr, rd);
      chk("count_reset", {1'b0, count_reset}, 2'b00);
      chk("l_reset", {1'b0, motor_l_reset}, {1'b0, lr});
      chk("r_reset", {1'b0, motor_r_reset}, {1'b0, rr});
      if (!lr) chk("l_dir", motor_l_direction, ld);
      if (!rr) chk("r_dir", motor_r_direction, rd);
      chk("done", {1'b0, action_done}, 2'b00);
      chk("timeout", {1'b0, action_timeout}, 2'b00);
    end

    if (acc)     $display("[%0t] accept action=%0d", $time, action);
    if (ex_done) $display("[%0t] action done timeout=%0b", $time, ex_to);

    if (reset) begin
      m_phase = 0; m_pend = 0; m_on = 0; m_periods = 0; m_seen = 0; m_cmd = C_BRAKE;
    end else begin
      m_phase = (m_phase + 1) % PLEN;
      m_pend = n_pend; m_pend_act = n_pend_act; m_on = n_on; m_act = n_act;
      m_periods = n_periods; m_seen = n_seen; m_cmd = n_cmd;
    end
    @(negedge clk);
  endtask

  task automatic run_to(input int p);
    int g;
    g = 0;
    while (m_phase != p && g < 2 * PLEN) begin
      step();
      g++;
    end
    if (m_phase != p) begin
      checks++;
      errors++;
      $display("FAIL run_to at %0t: phase %0d, expected %0d", $time, m_phase, p);
    end
  endtask

  task automatic offer(input logic [2:0] code);
    action = code;
    action_valid = 1'b1;
    step();
    action_valid = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    step();                      // reset held: SYNC-like outputs, idle
    chk("rst_count_reset", {1'b0, count_reset}, 2'b01);
    chk("rst_ready", {1'b0, action_ready}, 2'b01);
    reset = 1'b0;

    // idle: BRAKE in RUN
    run_to(6);
    chk("idle_l_dir", motor_l_direction, 2'b00);
    chk("idle_r_dir", motor_r_direction, 2'b00);
    chk("idle_l_reset", {1'b0, motor_l_reset}, 2'b00);

    // follow
    offer(3'b000);
    chk("follow_ready_low", {1'b0, action_ready}, 2'b00);
    sensor = 5'b11011; run_to(0); step(); run_to(6);
    chk("fwd_l_dir", motor_l_direction, 2'b10);
    chk("fwd_r_dir", motor_r_direction, 2'b01);
    sensor = 5'b10011; run_to(0); step(); run_to(6);
    chk("gleft_l_reset", {1'b0, motor_l_reset}, 2'b01);
    chk("gleft_r_dir", motor_r_direction, 2'b01);
    sensor = 5'b01111; run_to(0); step(); run_to(6);
    chk("sleft_l_dir", motor_l_direction, 2'b01);
    chk("sleft_r_dir", motor_r_direction, 2'b01);
    sensor = 5'b00000; run_to(0); #1;
    chk("cross_done", {1'b0, action_done}, 2'b01);
    step(); run_to(6);
    chk("cross_brake", motor_l_direction, 2'b00);

    // left turn, ends on the line
    offer(3'b001);
    sensor = 5'b11011; run_to(0); step(); run_to(6);
    chk("left_l_dir", motor_l_direction, 2'b01);
    run_to(0); step();           // 1st SYNC: on line, not yet seen white
    sensor = 5'b11111; run_to(0); step();
    sensor = 5'b11011; run_to(0); #1;
    chk("left_done", {1'b0, action_done}, 2'b01);
    chk("left_timeout", {1'b0, action_timeout}, 2'b00);
    step();

    // right turn, never finds the line
    run_to(4);
    offer(3'b010);
    sensor = 5'b11111; run_to(0); step();
    run_to(0); step();
    run_to(0); step();
    run_to(0); #1;
    chk("right_done", {1'b0, action_done}, 2'b01);
    chk("right_timeout", {1'b0, action_timeout}, 2'b01);
    step();

    // reverse
    run_to(4);
    offer(3'b100);
    chk("rev_ready_low", {1'b0, action_ready}, 2'b00);
    run_to(0); step(); run_to(6);
    chk("rev_l_dir", motor_l_direction, 2'b01);
    chk("rev_r_dir", motor_r_direction, 2'b10);
    run_to(0); step();
    run_to(0); #1;
    chk("rev_done", {1'b0, action_done}, 2'b01);
    step();
    chk("rev_ready_back", {1'b0, action_ready}, 2'b01);
    run_to(6);
    chk("rev_then_brake", motor_r_direction, 2'b00);

    // reset in the middle of a reverse
    run_to(3);
    offer(3'b100);
    run_to(0); step(); run_to(5);
    reset = 1'b1; step(); reset = 1'b0; #1;
    chk("midrst_count_reset", {1'b0, count_reset}, 2'b01);
    chk("midrst_ready", {1'b0, action_ready}, 2'b01);
    chk("midrst_no_done", {1'b0, action_done}, 2'b00);
    step(); run_to(6);
    chk("midrst_brake", motor_l_direction, 2'b00);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      sensor = SW'($urandom);
      action_valid = ($urandom_range(0, 3) == 0);
      action = 3'($urandom_range(0, 7));
      reset = ($urandom_range(0, 599) == 0);
      step();
    end
    reset = 1'b0;
    action_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
